// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - glitch filter and edge detector for a synchronized serial bit
// A new level is accepted only after DebounceCycles consecutive enabled samples.
module sync_debounce #(
  parameter int unsigned DebounceCycles = 4,
  parameter bit          ResetValue     = 1'b0,
  parameter int unsigned CntWidth       = $clog2(DebounceCycles + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  input  logic serial_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam logic [0:0] STABLE  = 1'b0;
  localparam logic [0:0] QUALIFY = 1'b1;

  localparam bit                  SingleCycle = (DebounceCycles == 1);
  localparam logic [CntWidth-1:0] CntLast     = CntWidth'(DebounceCycles - 1);
  localparam logic [CntWidth-1:0] CntOne      = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntZero     = '0;

  if (DebounceCycles == 0) begin : g_bad_param
    $fatal(1, "sync_debounce: DebounceCycles must be >= 1");
  end

  logic [0:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                busy_q, busy_d;
  logic                differs;

  assign differs = (serial_i != level_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    busy_d  = busy_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    if (en_i) begin
      case (state_q)
        STABLE: begin
          if (differs) begin
            if (SingleCycle) begin
              level_d = serial_i;
              rise_d  = serial_i;
              fall_d  = ~serial_i;
            end else begin
              state_d = QUALIFY;
              cnt_d   = CntOne;
              busy_d  = 1'b1;
            end
          end
        end

        QUALIFY: begin
          if (!differs) begin
            // Input fell back before the window closed: treat as a glitch.
            state_d = STABLE;
            cnt_d   = CntZero;
            busy_d  = 1'b0;
          end else if (cnt_q == CntLast) begin
            state_d = STABLE;
            cnt_d   = CntZero;
            busy_d  = 1'b0;
            level_d = serial_i;
            rise_d  = serial_i;
            fall_d  = ~serial_i;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end

        default: begin
          state_d = STABLE;
          cnt_d   = CntZero;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      state_q <= STABLE;
      cnt_q   <= CntZero;
      level_q <= ResetValue;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = busy_q;

endmodule
